// File: rtl/slow_mem_arb.sv
// slow_mem_arb: round-robin arbiter in front of a single-ported, fixed-latency
// line store shared by NCH requesters (channel 0 = I-side, 1 = D-side by default).
// One access is in flight at a time: grant -> LATENCY-1 BUSY cycles -> RESP.
// In RESP the ready pulse is high and any write has been committed.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   mem_read   [NCH]           per-channel read request
//   mem_write  [NCH]           per-channel write request (wins over read)
//   mem_addr   [NCH*28]        per-channel line address, channel k at [28k+27:28k]
//   mem_wdata  [NCH*LINE_W]    per-channel write line
//   mem_rdata  [NCH*LINE_W]    per-channel read line, held until next read completes
//   mem_ready  [NCH]           one-cycle completion pulse, at most one bit high
//   busy                       access in progress (BUSY or RESP)
//   grant_id   [3]             channel being served, 0 when idle
module slow_mem_arb #(
   parameter int unsigned NCH     = 2,
   parameter int unsigned LINE_W  = 128,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        mem_read,
   input  logic [NCH-1:0]        mem_write,
   input  logic [NCH*28-1:0]     mem_addr,
   input  logic [NCH*LINE_W-1:0] mem_wdata,
   output logic [NCH*LINE_W-1:0] mem_rdata,
   output logic [NCH-1:0]        mem_ready,
   output logic                  busy,
   output logic [2:0]            grant_id
);

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ID_W   = 3;
   localparam int unsigned MAXCH  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;

   logic [CNT_W-1:0]   cnt_q;
   logic [ID_W-1:0]    id_q;
   logic [ID_W-1:0]    rr_q;       // channel where the next search starts
   logic               op_wr_q;
   logic [IDX_W-1:0]   idx_q;
   logic [LINE_W-1:0]  wdata_q;

   logic [LINE_W-1:0]  store [DEPTH];

   logic [NCH-1:0]     pending_c;
   logic [MAXCH-1:0]   pend_ext_c;
   logic [ID_W-1:0]    ch_c;
   logic               gnt_vld_c;
   logic [ID_W-1:0]    gnt_id_c;
   logic               sel_wr_c;
   logic [IDX_W-1:0]   sel_idx_c;
   logic [LINE_W-1:0]  sel_wdata_c;
   logic               done_c;
   logic               unused_addr;

   assign pending_c  = mem_read | mem_write;
   assign pend_ext_c = MAXCH'(pending_c);

   // Only the low IDX_W bits of each address select a line; the rest wrap.
   assign unused_addr = ^mem_addr;

   // Last BUSY cycle: the counter is about to reach zero, next edge enters RESP.
   assign done_c = (state_q == ST_BUSY) && (cnt_q <= CNT_W'(1));

   // Round-robin search starting at rr_q.
   always_comb begin
      gnt_vld_c = 1'b0;
      gnt_id_c  = '0;
      ch_c      = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         ch_c = ID_W'((32'(rr_q) + i) % NCH);
         if (!gnt_vld_c && pend_ext_c[ch_c]) begin
            gnt_vld_c = 1'b1;
            gnt_id_c  = ch_c;
         end
      end
   end

   // Select the request fields of the channel being granted.
   always_comb begin
      sel_wr_c    = 1'b0;
      sel_idx_c   = '0;
      sel_wdata_c = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (32'(gnt_id_c) == k) begin
            sel_wr_c    = mem_write[k];
            sel_idx_c   = mem_addr[k*ADDR_W +: IDX_W];
            sel_wdata_c = mem_wdata[k*LINE_W +: LINE_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (gnt_vld_c) state_d = ST_BUSY;
         ST_BUSY: if (done_c)    state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Access context, round-robin pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         id_q      <= '0;
         rr_q      <= '0;
         op_wr_q   <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         mem_ready <= '0;
         mem_rdata <= '0;
         busy      <= 1'b0;
         grant_id  <= '0;
      end else begin
         mem_ready <= '0;
         busy      <= (state_d != ST_IDLE);
         if (state_d == ST_IDLE) begin
            grant_id <= '0;
         end else if (state_q == ST_IDLE) begin
            grant_id <= gnt_id_c;
         end else begin
            grant_id <= id_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (gnt_vld_c) begin
                  cnt_q   <= CNT_W'(LATENCY - 1);
                  id_q    <= gnt_id_c;
                  rr_q    <= ID_W'((32'(gnt_id_c) + 32'd1) % NCH);
                  op_wr_q <= sel_wr_c;
                  idx_q   <= sel_idx_c;
                  wdata_q <= sel_wdata_c;
               end
            end
            ST_BUSY: begin
               if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
               // Ready and read data are registered on the edge into RESP.
               if (done_c) begin
                  for (int unsigned k = 0; k < NCH; k++) begin
                     if (32'(id_q) == k) begin
                        mem_ready[k] <= 1'b1;
                        if (!op_wr_q) mem_rdata[k*LINE_W +: LINE_W] <= store[idx_q];
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Line store: not reset; a write commits on the edge into RESP unless rst wins.
   always_ff @(posedge clk) begin
      if (!rst && done_c && op_wr_q) begin
         store[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_slow_mem_arb.sv
// Directed bench for slow_mem_arb: default instance (NCH=2, LATENCY=4) plus a
// second instance (NCH=4, LATENCY=2) for the parameter sweep.
module tb_slow_mem_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default-parameter instance.
   logic          rst;
   logic [1:0]    mem_read, mem_write, mem_ready;
   logic [55:0]   mem_addr;
   logic [255:0]  mem_wdata, mem_rdata;
   logic          busy;
   logic [2:0]    grant_id;

   // NCH=4, LATENCY=2 instance.
   logic          rst4;
   logic [3:0]    rd4, wr4, rdy4;
   logic [111:0]  addr4;
   logic [63:0]   wd4, rdat4;
   logic          busy4;
   logic [2:0]    gid4;

   slow_mem_arb u_dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .busy(busy), .grant_id(grant_id)
   );

   slow_mem_arb #(.NCH(4), .LINE_W(16), .DEPTH(16), .LATENCY(2)) u_dut4 (
      .clk(clk), .rst(rst4), .mem_read(rd4), .mem_write(wr4),
      .mem_addr(addr4), .mem_wdata(wd4), .mem_rdata(rdat4),
      .mem_ready(rdy4), .busy(busy4), .grant_id(gid4)
   );

   typedef struct { int cyc; int ch; } ev_t;
   ev_t ev_q[$];
   ev_t ev4_q[$];
   int  cyc;
   int  base;
   int  n_assert;
   int  n_fail;
   bit  auto_drop;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample after the edge, log ready pulses, check one-hot ready.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      chk("onehot_a", 128'($onehot0(mem_ready)), 128'(1));
      chk("onehot_b", 128'($onehot0(rdy4)), 128'(1));
      for (int k = 0; k < 2; k++) begin
         if (mem_ready[k]) begin
            ev_q.push_back('{cyc, k});
            if (auto_drop) begin
               mem_read[k]  = 1'b0;
               mem_write[k] = 1'b0;
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (rdy4[k]) ev4_q.push_back('{cyc, k});
      end
   endtask

   // Single access on an idle default DUT; expects ready 4 cycles after request.
   task automatic xact(input int ch, input logic rd, input logic wr, input logic [27:0] a,
                       input logic [127:0] d, input string tag);
      int n;
      mem_read[ch]             = rd;
      mem_write[ch]            = wr;
      mem_addr[ch*28 +: 28]    = a;
      mem_wdata[ch*128 +: 128] = d;
      ev_q.delete();
      n = 0;
      while (ev_q.size() == 0 && n < 30) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, 128'(n), 128'(4));
      if (ev_q.size() > 0) chk({tag, "_ch"}, 128'(ev_q[0].ch), 128'(ch));
      mem_read[ch]  = 1'b0;
      mem_write[ch] = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rst4 = 1'b1;
      mem_read = '0; mem_write = '0; mem_addr = '0; mem_wdata = '0;
      rd4 = '0; wr4 = '0; addr4 = '0; wd4 = '0;
      cyc = 0; base = 0; n_assert = 0; n_fail = 0; auto_drop = 1'b1;

      // Reset values
      tick(); tick();
      chk("rst_ready", 128'(mem_ready), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_gid", 128'(grant_id), 128'(0));
      chk("rst_rdata0", mem_rdata[127:0], 128'(0));
      chk("rst_rdata1", mem_rdata[255:128], 128'(0));
      chk("rst4_busy", 128'(busy4), 128'(0));
      rst = 1'b0;
      tick();

      // Preload line 5 through channel 0
      xact(0, 1'b0, 1'b1, 28'h0000005, {16{8'hA5}}, "preload");

      // Single read by ch1: busy t+1..t+4, ready only at t+4
      mem_read[1] = 1'b1;
      mem_addr[55:28] = 28'h0000005;
      for (int c = 1; c <= 5; c++) begin
         tick();
         chk("rd_busy", 128'(busy), 128'(c <= 4));
         chk("rd_ready", 128'(mem_ready), (c == 4) ? 128'(2) : 128'(0));
         chk("rd_gid", 128'(grant_id), (c <= 4) ? 128'(1) : 128'(0));
         if (c == 4) chk("rd_data", mem_rdata[255:128], {16{8'hA5}});
      end
      chk("rd_data_held", mem_rdata[255:128], {16{8'hA5}});

      // ch1 writes 0x10, ch0 reads 0x10 while ch1 is busy
      ev_q.delete();
      base = cyc;
      mem_write[1] = 1'b1; mem_addr[55:28] = 28'h10; mem_wdata[255:128] = 128'h1234;
      tick();
      mem_read[0] = 1'b1; mem_addr[27:0] = 28'h10;
      for (int c = 2; c <= 10; c++) tick();
      chk("raw_nev", 128'(ev_q.size()), 128'(2));
      if (ev_q.size() == 2) begin
         chk("raw_ch_a", 128'(ev_q[0].ch), 128'(1));
         chk("raw_t_a", 128'(ev_q[0].cyc - base), 128'(4));
         chk("raw_ch_b", 128'(ev_q[1].ch), 128'(0));
         chk("raw_t_b", 128'(ev_q[1].cyc - base), 128'(9));
      end
      chk("raw_data", mem_rdata[127:0], 128'h1234);

      // Read+write together is a write; rdata slice unchanged
      xact(0, 1'b1, 1'b1, 28'h20, 128'h77, "rw");
      chk("rw_rdata_kept", mem_rdata[127:0], 128'h1234);
      xact(0, 1'b1, 1'b0, 28'h20, 128'h0, "rw_rd");
      chk("rw_rd_data", mem_rdata[127:0], 128'h77);

      // Address wrap modulo DEPTH
      xact(0, 1'b0, 1'b1, 28'h0000103, 128'hBEEF, "wrap_wr");
      xact(0, 1'b1, 1'b0, 28'h0000003, 128'h0, "wrap_rd");
      chk("wrap_data", mem_rdata[127:0], 128'hBEEF);

      // Reset two cycles after a ch1 write grant abandons the write
      xact(0, 1'b0, 1'b1, 28'h7, 128'h0, "l7_clr");
      ev_q.delete();
      mem_write[1] = 1'b1; mem_addr[55:28] = 28'h7; mem_wdata[255:128] = 128'hFFFF;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_ready", 128'(mem_ready), 128'(0));
      mem_write[1] = 1'b0;
      mem_read[0] = 1'b1; mem_addr[27:0] = 28'h7;
      for (int c = 1; c <= 5; c++) tick();
      chk("mid_rst_nev", 128'(ev_q.size()), 128'(1));
      if (ev_q.size() == 1) chk("mid_rst_ch", 128'(ev_q[0].ch), 128'(0));
      chk("mid_rst_l7", mem_rdata[127:0], 128'h0);

      // Contention from reset (last served was ch0): grants 0,1,0,1
      auto_drop = 1'b0;
      rst = 1'b1;
      mem_read = 2'b11; mem_addr = {28'h3, 28'h5};
      tick();
      chk("rst_prio_busy", 128'(busy), 128'(0));
      rst = 1'b0;
      ev_q.delete();
      base = cyc;
      for (int c = 1; c <= 20; c++) tick();
      chk("cont_nev", 128'(ev_q.size()), 128'(4));
      for (int k = 0; k < ev_q.size(); k++) begin
         chk("cont_ch", 128'(ev_q[k].ch), 128'(k % 2));
         chk("cont_t", 128'(ev_q[k].cyc - base), 128'(4 + 5 * k));
      end
      mem_read = 2'b00;
      auto_drop = 1'b1;
      tick(); tick();

      // NCH=4, LATENCY=2: grants 0,1,2,3,0, ready 2 cycles after each grant
      rd4 = 4'hF;
      ev4_q.delete();
      base = cyc;
      rst4 = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (c % 3 == 1) chk("sw_gid", 128'(gid4), 128'((c / 3) % 4));
      end
      chk("sw_nev", 128'(ev4_q.size()), 128'(5));
      for (int k = 0; k < ev4_q.size(); k++) begin
         chk("sw_ch", 128'(ev4_q[k].ch), 128'(k % 4));
         chk("sw_t", 128'(ev4_q[k].cyc - base), 128'(2 + 3 * k));
      end
      rd4 = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/slow_mem_arb.md
SLOW_MEM_ARB -- requirements
Module: slow_mem_arb

Interface
REQ-001 Parameter NCH, default 2, number of requester channels (1..8); channel 0 is the I-side and channel 1 the D-side in the default setup.
REQ-002 Parameter LINE_W, default 128, line width in bits.
REQ-003 Parameter DEPTH, default 256, number of lines stored (power of 2).
REQ-004 Parameter LATENCY, default 4, cycles from grant to ready (2..15).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-007 mem_read  input  NCH  per-channel read request.
REQ-008 mem_write  input  NCH  per-channel write request.
REQ-009 mem_addr  input  NCH*28  per-channel line address (byte address bits [31:4]); channel k occupies bits [28k+27:28k].
REQ-010 mem_wdata  input  NCH*LINE_W  per-channel write line; channel k occupies slice k.
REQ-011 mem_rdata  output  NCH*LINE_W  per-channel read line; channel k occupies slice k.
REQ-012 mem_ready  output  NCH  per-channel one-cycle completion pulse.
REQ-013 busy  output  1  high whenever an access is in progress (state BUSY or RESP).
REQ-014 grant_id  output  3  index of the channel currently being served; 0 when idle.

Function
REQ-015 Storage: DEPTH x LINE_W array, indexed by mem_addr[log2(DEPTH)-1:0] of the served channel.
REQ-016 Storage: upper address bits are ignored, so addresses wrap modulo DEPTH.
REQ-017 Request: a channel is pending while mem_read or mem_write is high; the requester holds addr, wdata and the request until its ready pulse.
REQ-018 Read and write high together on one channel: the access is a write and mem_rdata for that channel is unchanged.
REQ-019 State IDLE: if any channel is pending, grant one and go to BUSY; latch channel id, op, index and wdata; load a counter with LATENCY-1.
REQ-020 Arbitration: round-robin, starting the search at (last served channel + 1) mod NCH; after reset the search starts at channel 0.
REQ-021 State BUSY: decrement the counter each cycle; at 0 go to RESP.
REQ-022 State RESP: assert mem_ready[id] for exactly this cycle, then return to IDLE.
REQ-023 RESP, write: commit the latched wdata to storage.
REQ-024 RESP, read: register storage[index] into the rdata slice of that channel; the value appears with ready and is held until that channel's next read completes.
REQ-025 Latency: ready is high exactly LATENCY cycles after the grant cycle; the next grant is no earlier than the cycle after ready, giving one access per LATENCY+1 cycles.
REQ-026 At most one mem_ready bit is high in any cycle.
REQ-027 A request dropped before completion is not aborted: the access completes, a write is still committed, and ready still pulses.
REQ-028 A channel still requesting in the cycle after its ready is treated as a new request and arbitrated normally.
REQ-029 Requests arriving while BUSY wait; no request is lost or reordered within a channel.
REQ-030 Read-after-write to the same line, same or different channel, returns the newly written data.

Reset
REQ-031 On rst: state IDLE, counter 0, round-robin pointer so the next search starts at channel 0, mem_ready all 0, busy 0, grant_id 0, all mem_rdata slices 0.
REQ-032 Storage contents are not cleared by reset.
REQ-033 rst during BUSY or RESP abandons the access; an uncommitted write is not written and no ready pulse follows.
REQ-034 rst takes priority over every other event in the same cycle.

Verification
REQ-035 Single read: default parameters, line 0x05 preloaded with 0xA5..A5, ch1 read addr 0x0000005 granted at cycle t -> mem_ready[1]=1 only at t+4, rdata slice 1 = 0xA5..A5, busy high t+1..t+4.
REQ-036 Write then read: ch1 writes 0x1234 to addr 0x10, then ch0 reads addr 0x10 -> ch0 receives 0x1234; the second grant comes no earlier than 5 cycles after the first.
REQ-037 Contention: ch0 and ch1 both request continuously from reset -> grants alternate 0,1,0,1; each channel is served every 10 cycles; no cycle has two ready bits high.
REQ-038 Wrap: DEPTH=256, write 0xBEEF to addr 0x0000103, read addr 0x0000003 -> 0xBEEF.
REQ-039 Reset mid-write: ch1 write of 0xFFFF to line 7 (previously 0x0), rst pulsed 2 cycles after the grant -> no ready pulse, line 7 still reads 0x0, and the next grant after reset goes to ch0 if it is pending.
REQ-040 Parameter sweep: NCH=4 with LATENCY=2, all channels requesting -> grants 0,1,2,3,0 with ready exactly 2 cycles after each grant.
